// File: rtl/sha256_job_scheduler_pkg.sv
// Shared types for the SHA-256 job scheduler:
// FSM states, job descriptor and field widths.
package sha256_job_scheduler_pkg;

  localparam int ADDR_W = 16;
  localparam int TAG_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] input_addr;
    logic [ADDR_W-1:0] hash_addr;
    logic [TAG_W-1:0]  tag;
  } job_t;

endpackage

// File: rtl/sha256_job_scheduler_if.sv
// Job submission and completion handshakes of the scheduler.
// Master is the requester side, slave is the scheduler side.
interface sha256_job_scheduler_if
  import sha256_job_scheduler_pkg::*;
  ();

  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_input_addr;
  logic [ADDR_W-1:0] job_hash_addr;
  logic [TAG_W-1:0]  job_tag;

  logic              cmp_valid;
  logic              cmp_ready;
  logic [TAG_W-1:0]  cmp_tag;
  logic              cmp_err;

  modport master (
    output job_valid, job_input_addr,
    output job_hash_addr, job_tag,
    output cmp_ready,
    input  job_ready,
    input  cmp_valid, cmp_tag, cmp_err
  );

  modport slave (
    input  job_valid, job_input_addr,
    input  job_hash_addr, job_tag,
    input  cmp_ready,
    output job_ready,
    output cmp_valid, cmp_tag, cmp_err
  );

endinterface

// File: rtl/sha256_job_fifo.sv
// Circular job queue; the count register tells full from empty
// since both pointers wrap modulo DEPTH.
module sha256_job_fifo
  import sha256_job_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  job_t                   i_data,
  input  logic                   i_pop,
  output job_t                   o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  job_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Queues SHA-256 jobs and runs them one at a time on a
// single engine, with a per-phase timeout and completion records.
module sha256_job_scheduler
  import sha256_job_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  sha256_job_scheduler_if.slave        bus,
  output logic                         eng_start,
  output logic [ADDR_W-1:0]            eng_input_addr,
  output logic [ADDR_W-1:0]            eng_hash_addr,
  input  logic                         eng_done,
  output logic [$clog2(QUEUE_DEPTH):0] occupancy,
  output logic                         busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_eng_start;
  logic [ADDR_W-1:0] r_in_addr;
  logic [ADDR_W-1:0] r_hash_addr;
  logic [TAG_W-1:0]  r_tag;
  logic              r_cmp_valid;
  logic [TAG_W-1:0]  r_cmp_tag;
  logic              r_cmp_err;
  logic              r_busy;

  job_t w_job;
  job_t w_head;
  logic w_full;
  logic w_empty;
  logic w_launch;
  logic w_timeout;

  assign w_job = '{input_addr: bus.job_input_addr,
                   hash_addr:  bus.job_hash_addr,
                   tag:        bus.job_tag};

  assign w_launch  = (r_state == S_IDLE) & ~w_empty & eng_done;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  sha256_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.job_valid),
    .i_data  (w_job),
    .i_pop   (w_launch),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  assign bus.job_ready  = ~w_full;
  assign bus.cmp_valid  = r_cmp_valid;
  assign bus.cmp_tag    = r_cmp_tag;
  assign bus.cmp_err    = r_cmp_err;
  assign eng_start      = r_eng_start;
  assign eng_input_addr = r_in_addr;
  assign eng_hash_addr  = r_hash_addr;
  assign busy           = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_eng_start <= 1'b0;
      r_in_addr   <= '0;
      r_hash_addr <= '0;
      r_tag       <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_tag   <= '0;
      r_cmp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state     <= S_LAUNCH;
            r_in_addr   <= w_head.input_addr;
            r_hash_addr <= w_head.hash_addr;
            r_tag       <= w_head.tag;
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_eng_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT_BUSY;
        end
        // done is a level: only its fall proves the engine took the job
        S_WAIT_BUSY: begin
          if (!eng_done) begin
            r_state <= S_WAIT_DONE;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state     <= S_REPORT;
            r_cmp_valid <= 1'b1;
            r_cmp_tag   <= r_tag;
            r_cmp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (eng_done || w_timeout) begin
            r_state     <= S_REPORT;
            r_cmp_valid <= 1'b1;
            r_cmp_tag   <= r_tag;
            r_cmp_err   <= ~eng_done;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_REPORT: begin
          if (bus.cmp_ready) begin
            r_cmp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Scoreboard bench for sha256_job_scheduler with a level-done
// engine model; expected completions are queued at push time.
module tb_sha256_job_scheduler;
  import sha256_job_scheduler_pkg::*;

  localparam int QD = 4;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_job_scheduler_if bus();

  logic              eng_start;
  logic [15:0]       eng_in;
  logic [15:0]       eng_hash;
  logic [$clog2(QD):0] occupancy;
  logic              busy;

  logic eng_done_m = 1'b1;
  logic hold_low   = 1'b0;
  logic eng_stuck  = 1'b0;
  int   eng_cnt    = 0;
  int   eng_lat    = 200;
  wire  eng_done   = eng_done_m & ~hold_low;

  sha256_job_scheduler #(
    .QUEUE_DEPTH    (QD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .eng_start      (eng_start),
    .eng_input_addr (eng_in),
    .eng_hash_addr  (eng_hash),
    .eng_done       (eng_done),
    .occupancy      (occupancy),
    .busy           (busy)
  );

  typedef struct {
    logic [3:0] tag;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   n_start = 0;
  int   cyc     = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // engine: done drops after start, rises eng_lat cycles later
  always @(posedge clk) begin
    if (eng_start && !eng_stuck) begin
      eng_done_m <= 1'b0;
      eng_cnt    <= eng_lat;
    end else if (!eng_done_m) begin
      if (eng_cnt <= 1) eng_done_m <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && eng_start) begin
      n_start <= n_start + 1;
      chk("start_pulse", 32'(prev_start), 0);
    end
    prev_start <= eng_start;
    if (!rst && bus.cmp_valid && bus.cmp_ready) begin
      chk("cmp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        chk("cmp_tag", 32'(bus.cmp_tag), 32'(m_e.tag));
        chk("cmp_err", 32'(bus.cmp_err), 32'(m_e.err));
      end
    end
  end

  task automatic sb_add(input logic [3:0] t, input logic err);
    exp_t e;
    e.tag = t;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic push_job(input logic [15:0] a, input logic [15:0] h,
                          input logic [3:0] t, input logic err);
    bit ok = 0;
    @(posedge clk); #1;
    bus.job_valid      = 1'b1;
    bus.job_input_addr = a;
    bus.job_hash_addr  = h;
    bus.job_tag        = t;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (bus.job_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (ok) sb_add(t, err);
    bus.job_valid = 1'b0;
    chk("push_accept", 32'(ok), 1);
  endtask

  // kind: 0 done low, 1 done high, 2 cmp_valid, 3 eng_start
  task automatic wait_for(input string name, input int kind,
                          input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0:       ok = !eng_done;
        1:       ok = eng_done;
        2:       ok = bus.cmp_valid;
        default: ok = eng_start;
      endcase
    end
    chk(name, 32'(ok), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && occupancy == 0 && sb.size() == 0) ok = 1;
    end
    chk(name, 32'(ok), 1);
  endtask

  initial begin
    int s0;
    int c0;
    bit ok;
    bus.job_valid      = 1'b0;
    bus.job_input_addr = '0;
    bus.job_hash_addr  = '0;
    bus.job_tag        = '0;
    bus.cmp_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_occ",   32'(occupancy), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(bus.cmp_valid), 0);
    chk("rst_err",   32'(bus.cmp_err), 0);
    chk("rst_tag",   32'(bus.cmp_tag), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_in",    32'(eng_in), 0);
    chk("rst_hash",  32'(eng_hash), 0);
    chk("rst_ready", 32'(bus.job_ready), 1);

    // single job, 200-cycle engine
    s0 = n_start;
    push_job(16'h0000, 16'h0100, 4'd3, 1'b0);
    wait_for("t1_eng_busy", 0, 50);
    chk("t1_in",   32'(eng_in), 32'h0000);
    chk("t1_hash", 32'(eng_hash), 32'h0100);
    wait_for("t1_eng_done", 1, 400);
    chk("t1_cmp_early", 32'(bus.cmp_valid), 0);
    @(negedge clk);
    chk("t1_cmp_lat", 32'(bus.cmp_valid), 1);
    chk("t1_tag", 32'(bus.cmp_tag), 3);
    chk("t1_err", 32'(bus.cmp_err), 0);
    wait_idle("t1_idle", 50);
    chk("t1_starts", 32'(n_start - s0), 1);

    // fill queue while engine reports busy
    hold_low = 1'b1;
    eng_lat  = 30;
    for (int t = 0; t < 4; t++)
      push_job(16'h1000 + 16'(t), 16'h1100 + 16'(t), 4'(t), 1'b0);
    @(posedge clk); #1;
    bus.job_valid      = 1'b1;
    bus.job_input_addr = 16'h1004;
    bus.job_hash_addr  = 16'h1104;
    bus.job_tag        = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_occ_full", 32'(occupancy), 4);
      chk("t2_not_ready", 32'(bus.job_ready), 0);
      chk("t2_idle_hold", 32'(busy), 0);
    end
    @(posedge clk); #1;
    hold_low = 1'b0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.job_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (ok) sb_add(4'd4, 1'b0);
    bus.job_valid = 1'b0;
    chk("t2_fifth_push", 32'(ok), 1);
    wait_idle("t2_idle", 2000);

    // push coinciding with launch pop at occupancy 2
    hold_low = 1'b1;
    push_job(16'h3000, 16'h3100, 4'd5, 1'b0);
    push_job(16'h3001, 16'h3101, 4'd6, 1'b0);
    @(posedge clk); #1;
    hold_low           = 1'b0;
    bus.job_valid      = 1'b1;
    bus.job_input_addr = 16'h3002;
    bus.job_hash_addr  = 16'h3102;
    bus.job_tag        = 4'd7;
    @(negedge clk);
    chk("t44_pre_occ", 32'(occupancy), 2);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    sb_add(4'd7, 1'b0);
    @(negedge clk);
    chk("t44_occ", 32'(occupancy), 2);
    chk("t44_busy", 32'(busy), 1);
    chk("t44_in", 32'(eng_in), 32'h3000);
    wait_idle("t44_idle", 2000);

    // engine never drops done: WAIT_BUSY timeout
    eng_stuck = 1'b1;
    push_job(16'h2000, 16'h2100, 4'd9, 1'b1);
    wait_for("t3_start", 3, 20);
    c0 = cyc;
    wait_for("t3_cmp", 2, 5000);
    // one LAUNCH cycle plus TO cycles in WAIT_BUSY
    chk("t3_lat", 32'(cyc - c0), 32'(TO + 1));
    chk("t3_err", 32'(bus.cmp_err), 1);
    wait_idle("t3_idle", 20);
    eng_stuck = 1'b0;

    // completion back-pressure
    eng_lat       = 20;
    bus.cmp_ready = 1'b0;
    push_job(16'h4000, 16'h4100, 4'd10, 1'b0);
    push_job(16'h4001, 16'h4101, 4'd11, 1'b0);
    wait_for("t4_cmp", 2, 200);
    s0 = n_start;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t4_valid", 32'(bus.cmp_valid), 1);
      chk("t4_tag", 32'(bus.cmp_tag), 10);
    end
    chk("t4_no_start", 32'(n_start - s0), 0);
    chk("t4_occ", 32'(occupancy), 1);
    @(posedge clk); #1;
    bus.cmp_ready = 1'b1;
    wait_idle("t4_idle", 500);

    // reset in WAIT_DONE with two queued jobs
    eng_lat = 300;
    push_job(16'h5000, 16'h5100, 4'd12, 1'b0);
    push_job(16'h5001, 16'h5101, 4'd13, 1'b0);
    push_job(16'h5002, 16'h5102, 4'd14, 1'b0);
    wait_for("t5_eng_busy", 0, 20);
    repeat (5) @(negedge clk);
    chk("t5_pre_occ", 32'(occupancy), 2);
    chk("t5_pre_busy", 32'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t5_occ", 32'(occupancy), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(bus.cmp_valid), 0);
    s0 = n_start;
    repeat (400) @(negedge clk);
    chk("t5_no_start", 32'(n_start - s0), 0);
    chk("t5_still_idle", 32'(busy), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
